// File: rtl/semaforo_pkg.sv
// Shared types and constants for the pedestrian crossing block:
// FSM state encoding and active-low 7-segment patterns (gfedcba order).
package semaforo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WALK  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Decimal digit to segment pattern; anything above 9 shows blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/semaforo_peaton_debounce.sv
// Button conditioner: 2-flop synchronizer followed by a debouncer that
// only adopts a new level after DEBOUNCE_CYC consecutive identical samples.
// Reset state is "released" (level 1), matching an idle active-low key.
module debounce #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;

    // Metastability guard for the asynchronous key input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_pipe <= 2'b11;
        else      sync_pipe <= {sync_pipe[0], din};
    end

    // Count samples disagreeing with the accepted level; any agreeing
    // sample restarts the run. Fall pulses once on an accepted 1->0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_pipe[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= sync_pipe[1];
                cnt   <= '0;
                fall  <= ~sync_pipe[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/semaforo_peaton.sv
// Pedestrian request unit for a traffic-light controller. A debounced key
// press raises ped_req, a countdown escalates to ped_urgent, the grant
// (ped_ack) runs a timed walk phase, then a one-cycle done pulse.
// Optional feature: define SEMAFORO_PEATON_HEX_EN to drive HEX1/HEX0 with
// the decimal countdown; otherwise both displays are tied off (blank).
module semaforo_peaton
    import semaforo_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 500000,
    parameter int TICK_CYC     = 50000000,
    parameter int WAIT_S       = 9,
    parameter int WALK_S       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button,
    input  logic       ped_ack,
    output logic       ped_req,
    output logic       ped_urgent,
    output logic       walk,
    output logic       done,
    output logic [3:0] count,
    output logic [6:0] HEX1,
    output logic [6:0] HEX0
);

    localparam int         TW      = $clog2(TICK_CYC + 1);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_S);
    localparam logic [3:0] WALK_LD = 4'(WALK_S);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic          press;
    logic          btn_level_unused;

    debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .din   (button),
        .level (btn_level_unused),
        .fall  (press)
    );

    assign tick = (tcnt == TW'(TICK_CYC - 1));

    // Request/walk sequencer; every output is a flop updated here. The
    // one-second prescaler restarts on each phase entry so a phase lasts
    // exactly N ticks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ped_req    <= 1'b0;
            ped_urgent <= 1'b0;
            walk       <= 1'b0;
            done       <= 1'b0;
            count      <= 4'd0;
            tcnt       <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_WAIT || state == ST_WALK)
                tcnt <= tick ? '0 : tcnt + 1'b1;
            else
                tcnt <= '0;

            case (state)
                // Grant is ignored here; a press in the same cycle as ped_ack
                // only moves to WAIT, the grant is looked at from then on.
                ST_IDLE: begin
                    if (press) begin
                        state      <= ST_WAIT;
                        count      <= WAIT_LD;
                        ped_req    <= 1'b1;
                        ped_urgent <= (WAIT_LD == 4'd0);
                        tcnt       <= '0;
                    end
                end
                ST_WAIT: begin
                    if (ped_ack) begin
                        state      <= ST_WALK;
                        count      <= WALK_LD;
                        ped_req    <= 1'b0;
                        ped_urgent <= 1'b0;
                        walk       <= 1'b1;
                        tcnt       <= '0;
                    end else if (tick && count != 4'd0) begin
                        count <= count - 1'b1;
                        if (count == 4'd1) ped_urgent <= 1'b1;
                    end
                end
                // Controller abort (ack drops) ends the walk at once.
                ST_WALK: begin
                    if (!ped_ack || (tick && count <= 4'd1)) begin
                        state <= ST_CLEAR;
                        walk  <= 1'b0;
                        done  <= 1'b1;
                        count <= 4'd0;
                    end else if (tick) begin
                        count <= count - 1'b1;
                    end
                end
                // Hold until the controller releases the grant.
                ST_CLEAR: begin
                    if (!ped_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SEMAFORO_PEATON_HEX_EN
    logic [3:0] units;
    logic [3:0] tens;

    // Split the 0..15 countdown into decimal tens and units.
    always_comb begin
        units = count;
        tens  = 4'd0;
        if (count >= 4'd10) begin
            units = count - 4'd10;
            tens  = 4'd1;
        end
    end

    assign HEX0 = seg7(units);
    assign HEX1 = (tens == 4'd0) ? SEG_BLANK : seg7(tens);
`else
    assign HEX0 = SEG_BLANK;
    assign HEX1 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_semaforo_peaton.sv
// Directed bench for semaforo_peaton with a timeline-based reference model
// (phase + elapsed cycles) compared against the DUT every clock, plus
// hand-computed literal checks at the key moments of each scenario.
module tb_semaforo_peaton;

    localparam int DEB = 4;
    localparam int TCK = 10;
    localparam int WS  = 3;
    localparam int WK  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       button = 1'b1;
    logic       ped_ack = 1'b0;
    logic       ped_req, ped_urgent, walk, done;
    logic [3:0] count;
    logic [6:0] HEX1, HEX0;

    int n_chk  = 0;
    int n_fail = 0;
    int done_seen = 0;

    semaforo_peaton #(
        .DEBOUNCE_CYC(DEB), .TICK_CYC(TCK), .WAIT_S(WS), .WALK_S(WK)
    ) dut (
        .clk(clk), .rst(rst), .button(button), .ped_ack(ped_ack),
        .ped_req(ped_req), .ped_urgent(ped_urgent), .walk(walk), .done(done),
        .count(count), .HEX1(HEX1), .HEX0(HEX0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int seg(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ---------------- reference model ----------------
    typedef enum {M_IDLE, M_WAIT, M_WALK, M_CLEAR} mph_t;
    mph_t ph = M_IDLE;
    int   el = 0;          // cycles elapsed in current phase
    bit   lvl = 1'b1;      // accepted key level
    bit   press_q = 1'b0;  // accepted press, seen by sequencer next edge
    bit   smp[$];          // raw key samples, oldest first
    bit   m_same;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = M_IDLE; el = 0; lvl = 1'b1; press_q = 1'b0;
            smp.delete();
            for (int i = 0; i < DEB + 2; i++) smp.push_back(1'b1);
        end else begin
            case (ph)
                M_IDLE:  if (press_q) begin ph = M_WAIT; el = 0; end
                M_WAIT:  if (ped_ack) begin ph = M_WALK; el = 0; end else el++;
                M_WALK:  begin
                    el++;
                    if (!ped_ack || el == WK * TCK) begin ph = M_CLEAR; el = 0; end
                end
                M_CLEAR: if (!ped_ack) ph = M_IDLE; else el++;
            endcase
            // Key seen through two sync stages: window = last DEB synced samples.
            smp.push_back(button);
            void'(smp.pop_front());
            press_q = 1'b0;
            m_same = 1'b1;
            for (int i = 1; i < DEB; i++) if (smp[i] != smp[0]) m_same = 1'b0;
            if (m_same && smp[0] != lvl) begin
                lvl = smp[0];
                press_q = !lvl;
            end
        end
    end

    function automatic int exp_count();
        if (ph == M_WAIT) return (el / TCK >= WS) ? 0 : WS - el / TCK;
        if (ph == M_WALK) return WK - el / TCK;
        return 0;
    endfunction

    function automatic int exp_hex0(input int c);
`ifdef SEMAFORO_PEATON_HEX_EN
        return seg(c % 10);
`else
        return 7'h7F;
`endif
    endfunction

    function automatic int exp_hex1(input int c);
`ifdef SEMAFORO_PEATON_HEX_EN
        return (c >= 10) ? seg(c / 10) : 7'h7F;
`else
        return 7'h7F;
`endif
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("ped_req",    int'(ped_req),    int'(ph == M_WAIT));
            chk("ped_urgent", int'(ped_urgent), int'(ph == M_WAIT && el >= WS * TCK));
            chk("walk",       int'(walk),       int'(ph == M_WALK));
            chk("done",       int'(done),       int'(ph == M_CLEAR && el == 0));
            chk("count",      int'(count),      exp_count());
            chk("HEX0",       int'(HEX0),       exp_hex0(exp_count()));
            chk("HEX1",       int'(HEX1),       exp_hex1(exp_count()));
            if (done) done_seen++;
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int hex0_zero;
`ifdef SEMAFORO_PEATON_HEX_EN
        hex0_zero = 7'b1000000;
`else
        hex0_zero = 7'h7F;
`endif
        step(3);
        chk("rst_req",   int'(ped_req), 0);
        chk("rst_urg",   int'(ped_urgent), 0);
        chk("rst_walk",  int'(walk), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_hex0",  int'(HEX0), hex0_zero);
        chk("rst_hex1",  int'(HEX1), 7'h7F);
        rst = 1'b1;
        step(4);

        // Glitch: 3 low samples are rejected.
        button = 1'b0; step(3); button = 1'b1; step(15);
        chk("glitch_req", int'(ped_req), 0);

        // Normal cycle.
        button = 1'b0; step(6);
        chk("norm_lat_req0", int'(ped_req), 0);
        step(1);
        chk("norm_req", int'(ped_req), 1);
        chk("norm_cnt3", int'(count), 3);
        step(3); button = 1'b1; step(12);
        chk("norm_cnt2_wait", int'(count), 2);
        ped_ack = 1'b1; step(1);
        chk("grant_req", int'(ped_req), 0);
        chk("grant_walk", int'(walk), 1);
        chk("grant_cnt", int'(count), 2);
        step(19);
        chk("walk_end_walk", int'(walk), 1);
        chk("walk_end_cnt", int'(count), 1);
        chk("walk_end_done0", int'(done), 0);
        step(1);
        chk("clear_done", int'(done), 1);
        chk("clear_walk", int'(walk), 0);
        step(1);
        chk("clear_hold_done", int'(done), 0);
        ped_ack = 1'b0; step(2);
        chk("idle_req", int'(ped_req), 0);

        // Urgency, with an extra press inside WAIT that must be ignored.
        button = 1'b0; step(7);
        chk("urg_req", int'(ped_req), 1);
        chk("urg_cnt3", int'(count), 3);
        button = 1'b1; step(8);
        button = 1'b0; step(8);
        button = 1'b1; step(12);
        step(1);
        chk("urg_cnt1", int'(count), 1);
        chk("urg_pre", int'(ped_urgent), 0);
        step(1);
        chk("urg_cnt0", int'(count), 0);
        chk("urg_set", int'(ped_urgent), 1);
        step(10);
        chk("urg_hold", int'(ped_urgent), 1);
        chk("urg_req_hold", int'(ped_req), 1);

        // Abort: grant, then drop ack 5 cycles into WALK.
        ped_ack = 1'b1; step(1);
        chk("abort_walk", int'(walk), 1);
        chk("abort_urg_clr", int'(ped_urgent), 0);
        step(4);
        ped_ack = 1'b0; step(1);
        chk("abort_done", int'(done), 1);
        chk("abort_walk0", int'(walk), 0);
        step(1);
        chk("abort_done1", int'(done), 0);
        step(2);
        chk("done_pulses", done_seen, 2);

        // Simultaneous press and ack in IDLE.
        button = 1'b0; step(6);
        ped_ack = 1'b1; step(1);
        chk("sim_wait_req", int'(ped_req), 1);
        chk("sim_wait_walk", int'(walk), 0);
        step(1);
        chk("sim_walk", int'(walk), 1);
        chk("sim_walk_cnt", int'(count), 2);
        button = 1'b1; step(5);

        // Asynchronous reset mid-WALK.
        #2 rst = 1'b0;
        #1;
        chk("arst_walk",  int'(walk), 0);
        chk("arst_req",   int'(ped_req), 0);
        chk("arst_urg",   int'(ped_urgent), 0);
        chk("arst_done",  int'(done), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_hex0",  int'(HEX0), hex0_zero);
        chk("arst_hex1",  int'(HEX1), 7'h7F);
        @(negedge clk);
        rst = 1'b1; ped_ack = 1'b0;
        step(5);
        chk("post_rst_done_pulses", done_seen, 2);
        chk("post_rst_walk", int'(walk), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/semaforo_peaton.md
SEMAFORO_PEATON -- requirements
Module: semaforo_peaton

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 500000, clk cycles the button must stay stable before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter TICK_CYC, default 50000000, clk cycles per one-second tick.
REQ-003 Parameter WAIT_S, default 9, maximum seconds a pending pedestrian request waits before ped_req is forced urgent.
REQ-004 Parameter WALK_S, default 5, seconds of walk phase after grant.
REQ-005 Port: clk  in  1  system clock; the block uses this single clock only.
REQ-006 Port: rst  in  1  reset; asynchronous, active-low.
REQ-007 Port: button  in  1  raw pedestrian key, asynchronous to clk, active-low (pressed = 0).
REQ-008 Port: ped_ack  in  1  grant from the traffic-light controller; level, held high while cars are stopped.
REQ-009 Port: ped_req  out  1  pending pedestrian request to the controller.
REQ-010 Port: ped_urgent  out  1  request has waited WAIT_S seconds.
REQ-011 Port: walk  out  1  walk lamp.
REQ-012 Port: done  out  1  one-cycle pulse at the end of the walk phase.
REQ-013 Port: count  out  4  remaining seconds (wait or walk), binary.
REQ-014 Port: HEX1, HEX0  out  7 each  active-low 7-segment display of count (tens, units).

Function
REQ-015 button passes through a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYC consecutive identical samples.
REQ-016 A press event is one clk pulse on the debounced 1->0 transition; holding the key produces no further events.
REQ-017 FSM states: IDLE, WAIT, WALK, CLEAR.
REQ-018 IDLE: press -> WAIT, count loads WAIT_S, tick counter clears.
REQ-019 WAIT: ped_req = 1; count decrements on each tick and saturates at 0; when count reaches 0, ped_urgent = 1.
REQ-020 WAIT: ped_ack sampled high -> WALK on the next clk, count loads WALK_S, ped_req drops in that same cycle.
REQ-021 WALK: walk = 1; count decrements per tick; tick with count = 1 -> CLEAR.
REQ-022 WALK: ped_ack dropping early -> CLEAR immediately (controller abort).
REQ-023 CLEAR: done = 1 for exactly one cycle, count = 0, then -> IDLE only once ped_ack is low; ped_ack still high -> remain in CLEAR with done low.
REQ-024 Presses in WAIT, WALK and CLEAR are ignored; presses are not queued.
REQ-025 ped_ack high in IDLE is ignored.
REQ-026 A press and ped_ack arriving in the same cycle in IDLE -> WAIT only; the grant is evaluated from the next cycle.
REQ-027 The tick counter wraps from TICK_CYC-1 to 0 and runs only in WAIT and WALK.
REQ-028 All outputs are registered; latency from debounced edge to ped_req is 1 cycle.

Reset
REQ-029 rst low asynchronously forces: state IDLE, ped_req 0, ped_urgent 0, walk 0, done 0, count 0, debouncer level 1 (released), all counters 0.
REQ-030 Reset mid-WALK drops walk immediately and emits no done.

Configuration
REQ-031 Macro SEMAFORO_PEATON_HEX_EN defined: HEX1/HEX0 show count in decimal, with HEX1 blank when count < 10.
REQ-032 Macro SEMAFORO_PEATON_HEX_EN undefined: HEX1 and HEX0 are tied to 7'b1111111 (all segments off), and no decoder logic is generated.

Structure
REQ-033 FSM state encodings and segment constants (digits 0-9, blank) live in the shared package semaforo_pkg.
REQ-034 Debouncing is a sub-module named debounce, parameterised by DEBOUNCE_CYC, with a synchronized-level output and a fall-pulse output.

Verification (DEBOUNCE_CYC=4, TICK_CYC=10, WAIT_S=3, WALK_S=2)
REQ-035 Glitch: button low for 3 cycles, then high -> no event, ped_req stays 0.
REQ-036 Normal cycle: button low for 10 cycles -> ped_req=1, count=3; ped_ack high after 15 cycles -> ped_req=0, walk=1, count=2; 20 cycles later -> done pulse, walk=0; ped_ack low -> IDLE.
REQ-037 Urgency: press with no ack -> count reaches 0 after 30 cycles, ped_urgent=1, ped_req held at 1.
REQ-038 Abort: ped_ack drops 5 cycles into WALK -> CLEAR next cycle, single done pulse.
REQ-039 Reset: rst asserted low mid-WALK -> all outputs 0 asynchronously, HEX0=7'b1000000 with SEMAFORO_PEATON_HEX_EN defined, all-ones without.
REQ-040 Simultaneous: press and ped_ack in the same IDLE cycle -> WAIT entered, WALK one cycle later.
